// File: rtl/opser_pkg.sv
// rtl/opser_pkg.sv - shared states, defaults and unlock key for the operand serializer
package opser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        LOCKED,
        DEAD
    } opser_state_e;

    localparam int          OPSER_WIDTH_DEF = 8;
    localparam int          OPSER_GAP_DEF   = 2;
    localparam logic [15:0] OPSER_KEY       = 16'hA55A;

endpackage

// File: rtl/opser_shreg.sv
// rtl/opser_shreg.sv - load/shift-right register exposing its LSB
module opser_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q >> 1;
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/opnd_serializer.sv
// rtl/opnd_serializer.sv - LSB-first two-line operand serializer with post-word zero gap
// Optional unlock-key gating is built when OPSER_LOCK_EN is defined.
module opnd_serializer
    import opser_pkg::*;
#(
    parameter int WIDTH      = OPSER_WIDTH_DEF,
    parameter int GAP_CYCLES = OPSER_GAP_DEF,
    parameter int CNT_W      = 6
`ifdef OPSER_LOCK_EN
    ,
    parameter logic [15:0] KEY = OPSER_KEY
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             line1,
    output logic             line2,
    output logic             frame,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);
`ifdef OPSER_LOCK_EN
    localparam opser_state_e RESET_ST = LOCKED;
`else
    localparam opser_state_e RESET_ST = IDLE;
`endif

    opser_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load, shift;
    logic             sa_lsb, sb_lsb;
    logic             hs;

    assign hs = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RESET_ST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef OPSER_LOCK_EN
    logic key_ok;
    assign key_ok = (8'(32'(in_a)) == KEY[7:0]) && (8'(32'(in_b)) == KEY[15:8]);
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt == LAST_BIT) begin
                    cnt_nxt   = '0;
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == LAST_GAP) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`ifdef OPSER_LOCK_EN
            // The unlock word is consumed here and never reaches the shift registers.
            LOCKED: begin
                if (hs) begin
                    state_nxt = key_ok ? IDLE : DEAD;
                end
            end
            DEAD: state_nxt = DEAD;
`endif
            default: state_nxt = RESET_ST;
        endcase
    end

    opser_shreg #(.WIDTH(WIDTH)) u_sa (
        .clk   (clock),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_a),
        .lsb   (sa_lsb)
    );

    opser_shreg #(.WIDTH(WIDTH)) u_sb (
        .clk   (clock),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (in_b),
        .lsb   (sb_lsb)
    );

`ifdef OPSER_LOCK_EN
    assign in_ready = (state == IDLE) || (state == LOCKED);
`else
    assign in_ready = (state == IDLE);
`endif
    assign frame = (state == SHIFT);
    assign line1 = frame && sa_lsb;
    assign line2 = frame && sb_lsb;
    assign done  = frame && (cnt == LAST_BIT);

endmodule

// File: tb/tb_opnd_serializer.sv
// tb/tb_opnd_serializer.sv - randomized self-checking bench for opnd_serializer
module tb_opnd_serializer;
    import opser_pkg::*;

    localparam int W = 8;
    localparam int G = 2;

    logic         clock    = 1'b0;
    logic         reset    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a     = '0;
    logic [W-1:0] in_b     = '0;
    logic         in_ready, line1, line2, frame, done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    opnd_serializer #(.WIDTH(W), .GAP_CYCLES(G), .CNT_W(6)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .line1    (line1),
        .line2    (line2),
        .frame    (frame),
        .done     (done)
    );

    // Reference: a word accepted at edge n occupies observation slots d = 1..W+G after it.
    bit           have    = 1'b0;
    bit           m_ready = 1'b1;
    int           n_edge  = 0;
    int           e       = 0;
    logic [W-1:0] wa, wb;
    logic [W-1:0] obs1, obs2;
    int           done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
        int   d;
        logic x_ready, x_l1, x_l2, x_frame, x_done;
        @(negedge clock);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        reset    = r;
        @(posedge clock);
        if (r) begin
            have = 1'b0;
        end else if (m_ready && v) begin
            have   = 1'b1;
            n_edge = e;
            wa     = a;
            wb     = b;
        end
        d       = e - n_edge + 1;
        x_ready = 1'b1;
        x_l1    = 1'b0;
        x_l2    = 1'b0;
        x_frame = 1'b0;
        x_done  = 1'b0;
        if (have && d <= W + G) begin
            x_ready = 1'b0;
            if (d <= W) begin
                x_frame = 1'b1;
                x_l1    = wa[d-1];
                x_l2    = wb[d-1];
                x_done  = (d == W);
            end
        end
        m_ready = x_ready;
        #1;
        check("in_ready", 32'(in_ready), 32'(x_ready));
        check("line1",    32'(line1),    32'(x_l1));
        check("line2",    32'(line2),    32'(x_l2));
        check("frame",    32'(frame),    32'(x_frame));
        check("done",     32'(done),     32'(x_done));
        if (have && d >= 1 && d <= W) begin
            obs1[d-1] = line1;
            obs2[d-1] = line2;
        end
        if (done === 1'b1) done_seen++;
        e++;
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0);

        obs1 = '0;
        obs2 = '0;
        step(1'b1, 8'hB5, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, W'($urandom()), W'($urandom()), 1'b0);
        check("b5_line1_word", 32'(obs1), 32'h0000_00B5);
        check("b5_line2_word", 32'(obs2), 32'h0000_003C);
        check("b5_ready_back", 32'(in_ready), 32'd1);

        step(1'b0, 8'h00, 8'h00, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 33; i++) step(1'b1, W'($urandom()), W'($urandom()), 1'b0);
        check("three_words_done", 32'(done_seen), 32'd3);

        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 8'h11, 8'h22, 1'b1);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        ra   = W'($urandom());
        rb   = W'($urandom());
        obs1 = '0;
        obs2 = '0;
        step(1'b1, ra, rb, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
        check("after_rst_line1_word", 32'(obs1), 32'(ra));
        check("after_rst_line2_word", 32'(obs2), 32'(rb));

        for (int i = 0; i < 400; i++) begin
            step(($urandom() % 4) != 0, W'($urandom()), W'($urandom()), ($urandom() % 50) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
